// File: rtl/wtile_stream_writer.sv
`default_nettype none
// ============================================================================
//  Module      : wtile_stream_writer
//  Description : Streams a weight tile into the weight-SRAM CPU write port.
//                Beat n of a transfer is written to row n mod M, column
//                n div M (k-outer, row-inner), one cycle after acceptance.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n                 rising-edge clock, async active-low reset
//    cfg_start, cfg_k_len       one-cycle start request, column count
//    s_valid/s_data/s_mask/
//    s_last, s_ready            input weight stream with handshake
//    cpu_w_we/row/k/wdata/wmask weight-SRAM write port (registered)
//    col_done, col_k            pulse when column k's last row is written
//    busy, done, err            status: in transfer, completion, error pulses
// ============================================================================
module wtile_stream_writer #(
    parameter int M      = 8,
    parameter int KMAX   = 1024,
    parameter int DATA_W = 32,
    parameter int BYTE_W = DATA_W / 8,
    parameter int ROW_W  = (M <= 1) ? 1 : $clog2(M),
    parameter int K_W    = (KMAX <= 1) ? 1 : $clog2(KMAX)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic [K_W:0]      cfg_k_len,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic [BYTE_W-1:0] s_mask,
    input  logic              s_last,
    output logic              s_ready,
    output logic              cpu_w_we,
    output logic [ROW_W-1:0]  cpu_w_row,
    output logic [K_W-1:0]    cpu_w_k,
    output logic [DATA_W-1:0] cpu_w_wdata,
    output logic [BYTE_W-1:0] cpu_w_wmask,
    output logic              col_done,
    output logic [K_W-1:0]    col_k,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(M - 1);
    localparam logic [K_W:0]     c_LEN_MAX  = (K_W + 1)'(KMAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [ROW_W-1:0]  r_row;
    logic [K_W-1:0]    r_k;
    logic [K_W:0]      r_len;

    logic              r_we;
    logic [ROW_W-1:0]  r_wrow;
    logic [K_W-1:0]    r_wk;
    logic [DATA_W-1:0] r_wdata;
    logic [BYTE_W-1:0] r_wmask;
    logic              r_col_done;
    logic [K_W-1:0]    r_col_k;
    logic              r_done;
    logic              r_err;

    logic w_len_ok;
    logic w_acc;
    logic w_row_last;
    logic w_final;

    assign w_len_ok   = (cfg_k_len != '0) && (cfg_k_len <= c_LEN_MAX);
    assign w_acc      = s_valid && (r_state == S_RUN);
    assign w_row_last = (r_row == c_ROW_LAST);
    // Final beat: last row of the last requested column.
    assign w_final    = w_row_last && ({1'b0, r_k} == (r_len - 1'b1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. An early s_last also ends the transfer, so DRAIN
    // is entered on either the final beat or a premature last marker.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (cfg_start && w_len_ok) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_acc && (w_final || s_last)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counters and registered write-port / status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row      <= '0;
            r_k        <= '0;
            r_len      <= '0;
            r_we       <= 1'b0;
            r_wrow     <= '0;
            r_wk       <= '0;
            r_wdata    <= '0;
            r_wmask    <= '0;
            r_col_done <= 1'b0;
            r_col_k    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_we       <= w_acc;
            r_col_done <= w_acc && w_row_last;
            r_done     <= w_acc && w_final;
            // Error on a bad length request, or when s_last disagrees with
            // the beat's position (early marker or missing marker).
            r_err      <= ((r_state == S_IDLE) && cfg_start && !w_len_ok) ||
                          (w_acc && (s_last != w_final));

            if ((r_state == S_IDLE) && cfg_start && w_len_ok) begin
                r_row <= '0;
                r_k   <= '0;
                r_len <= cfg_k_len;
            end

            if (w_acc) begin
                r_wrow  <= r_row;
                r_wk    <= r_k;
                r_wdata <= s_data;
                r_wmask <= s_mask;
                if (w_row_last) begin
                    r_col_k <= r_k;
                    r_row   <= '0;
                    r_k     <= r_k + K_W'(1);
                end else begin
                    r_row   <= r_row + ROW_W'(1);
                end
            end
        end
    end

    assign s_ready     = (r_state == S_RUN);
    assign busy        = (r_state != S_IDLE);
    assign cpu_w_we    = r_we;
    assign cpu_w_row   = r_wrow;
    assign cpu_w_k     = r_wk;
    assign cpu_w_wdata = r_wdata;
    assign cpu_w_wmask = r_wmask;
    assign col_done    = r_col_done;
    assign col_k       = r_col_k;
    assign done        = r_done;
    assign err         = r_err;

endmodule
`default_nettype wire
